gbp_ftq: RTL

//   Fetch target queue on the predictor-index return path of the global branch predictor.
//   - At fetch time, the frontend pushes the GHR-hashed predictor index and the unaligned flag for each fetch block.
//   - At resolve time, execute quotes the returned FTQ id; this block replays the stored index as the predictor update.
//   - Sits between frontend (push), execute (resolve) and commit (pop).

---
 rtl/gbp_ftq_if.sv | 47 ++++
 rtl/gbp_ftq.sv | 126 ++++++++++++
 2 files changed

// File: rtl/gbp_ftq_if.sv
// Interface bundling the frontend push, execute resolve, commit pop and predictor-update
// signals of the GBP fetch target queue; slave is the queue, master is the surrounding pipeline.
interface gbp_ftq_if #(
    parameter int unsigned VLEN = 32,
    parameter int unsigned IDXW = 6,
    parameter int unsigned IDW  = 4
);
    logic            flush_i;
    logic            debug_mode_i;
    logic            push_valid_i;
    logic            push_ready_o;
    logic [IDXW-1:0] push_index_i;
    logic            push_unaligned_i;
    logic [IDW-1:0]  push_id_o;
    logic            resolve_valid_i;
    logic [IDW-1:0]  resolve_id_i;
    logic [VLEN-1:0] resolve_pc_i;
    logic            resolve_taken_i;
    logic            resolve_mispredict_i;
    logic            commit_i;
    logic            update_valid_o;
    logic [VLEN-1:0] update_pc_o;
    logic            update_taken_o;
    logic [IDXW-1:0] update_index_o;
    logic            update_is_unaligned_o;
    logic [IDW-1:0]  count_o;

    modport slave (
        input  flush_i, debug_mode_i,
        input  push_valid_i, push_index_i, push_unaligned_i,
        output push_ready_o, push_id_o,
        input  resolve_valid_i, resolve_id_i, resolve_pc_i, resolve_taken_i, resolve_mispredict_i,
        input  commit_i,
        output update_valid_o, update_pc_o, update_taken_o, update_index_o, update_is_unaligned_o,
        output count_o
    );

    modport master (
        output flush_i, debug_mode_i,
        output push_valid_i, push_index_i, push_unaligned_i,
        input  push_ready_o, push_id_o,
        output resolve_valid_i, resolve_id_i, resolve_pc_i, resolve_taken_i, resolve_mispredict_i,
        output commit_i,
        input  update_valid_o, update_pc_o, update_taken_o, update_index_o, update_is_unaligned_o,
        input  count_o
    );
endinterface

// File: rtl/gbp_ftq.sv
// Fetch target queue replaying stored global-predictor indices on branch resolve.
// Define GBP_FTQ_BYPASS_EN for combinational (0-cycle) update outputs; default is registered.
module gbp_ftq #(
    parameter int unsigned VLEN     = 32,
    parameter int unsigned IDXW     = 6,
    parameter bit          DEBUG_EN = 1'b1,
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned IDW      = $clog2(DEPTH) + 1
) (
    input logic        clk_i,
    input logic        rst_ni,
    gbp_ftq_if.slave   bus
);
    localparam int unsigned SW = IDW - 1;
    localparam logic [IDW-1:0] ONE = IDW'(1);

    logic [IDW-1:0]  head_q, head_d, tail_q, tail_d;
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [IDXW:0]   mem_q [DEPTH];

    logic [IDW-1:0]  count;
    logic [IDW-1:0]  resolveOff;
    logic [SW-1:0]   resolveSlot;
    logic            full, empty, mispredictReq, pushFire, resolveHit, doCommit, updateEn;

    assign count         = tail_q - head_q;
    assign full          = (head_q[SW-1:0] == tail_q[SW-1:0]) && (head_q[IDW-1] != tail_q[IDW-1]);
    assign empty         = (head_q == tail_q);
    assign mispredictReq = bus.resolve_valid_i && bus.resolve_mispredict_i;

    assign bus.push_ready_o = !full && !bus.flush_i && !mispredictReq;
    assign bus.push_id_o    = tail_q;
    assign bus.count_o      = count;
    assign pushFire         = bus.push_valid_i && bus.push_ready_o;

    // A resolve only counts when its id lies inside the live window [head, tail).
    assign resolveOff  = bus.resolve_id_i - head_q;
    assign resolveSlot = bus.resolve_id_i[SW-1:0];
    assign resolveHit  = bus.resolve_valid_i && !bus.flush_i && (resolveOff < count) && valid_q[resolveSlot];
    assign doCommit    = bus.commit_i && !empty && !bus.flush_i;
    assign updateEn    = resolveHit && !(DEBUG_EN && bus.debug_mode_i);

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        valid_d = valid_q;
        if (bus.flush_i) begin
            head_d  = tail_q;
            valid_d = '0;
        end else begin
            // Mispredict rewinds tail just past the branch; everything younger is discarded.
            if (resolveHit && bus.resolve_mispredict_i) begin
                tail_d = bus.resolve_id_i + ONE;
                for (int i = 0; i < DEPTH; i++) begin
                    if (SW'(SW'(i) - head_q[SW-1:0]) > resolveOff[SW-1:0]) begin
                        valid_d[i] = 1'b0;
                    end
                end
            end
            if (doCommit) begin
                head_d = head_q + ONE;
                valid_d[head_q[SW-1:0]] = 1'b0;
            end
            if (pushFire) begin
                tail_d = tail_q + ONE;
                valid_d[tail_q[SW-1:0]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q  <= '0;
            tail_q  <= '0;
            valid_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (pushFire) begin
            mem_q[tail_q[SW-1:0]] <= {bus.push_unaligned_i, bus.push_index_i};
        end
    end

`ifdef GBP_FTQ_BYPASS_EN
    assign bus.update_valid_o        = updateEn;
    assign bus.update_pc_o           = resolveHit ? bus.resolve_pc_i : '0;
    assign bus.update_taken_o        = resolveHit && bus.resolve_taken_i;
    assign bus.update_index_o        = resolveHit ? mem_q[resolveSlot][IDXW-1:0] : '0;
    assign bus.update_is_unaligned_o = resolveHit && mem_q[resolveSlot][IDXW];
`else
    logic            updateValid_q;
    logic [VLEN-1:0] updatePc_q;
    logic            updateTaken_q;
    logic [IDXW-1:0] updateIndex_q;
    logic            updateUnaligned_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            updateValid_q     <= 1'b0;
            updatePc_q        <= '0;
            updateTaken_q     <= 1'b0;
            updateIndex_q     <= '0;
            updateUnaligned_q <= 1'b0;
        end else begin
            updateValid_q <= updateEn;
            if (resolveHit) begin
                updatePc_q        <= bus.resolve_pc_i;
                updateTaken_q     <= bus.resolve_taken_i;
                updateIndex_q     <= mem_q[resolveSlot][IDXW-1:0];
                updateUnaligned_q <= mem_q[resolveSlot][IDXW];
            end
        end
    end

    assign bus.update_valid_o        = updateValid_q;
    assign bus.update_pc_o           = updatePc_q;
    assign bus.update_taken_o        = updateTaken_q;
    assign bus.update_index_o        = updateIndex_q;
    assign bus.update_is_unaligned_o = updateUnaligned_q;
`endif
endmodule
